// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and TX-controller signal bundle for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) ();
  logic [N_REQ-1:0]    req;
  logic [N_REQ*8-1:0]  req_data;
  logic [N_REQ*15-1:0] req_bytes;
  logic [N_REQ*2-1:0]  req_delay;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ack;
  logic [IDW-1:0]      active_id;
  logic                arb_busy;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic [14:0]         tx_num_bytes;
  logic [1:0]          tx_delay;
  logic                tx_busy;
  logic                tx_done;
  logic                err;

  // Arbiter side: drives the TX controller and the requester acknowledgements.
  modport master (
    input  req, req_data, req_bytes, req_delay, tx_busy, tx_done,
    output grant, ack, active_id, arb_busy, tx_start, tx_data,
           tx_num_bytes, tx_delay, err
  );

  // Requester/controller side.
  modport slave (
    output req, req_data, req_bytes, req_delay, tx_busy, tx_done,
    input  grant, ack, active_id, arb_busy, tx_start, tx_data,
           tx_num_bytes, tx_delay, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART TX controller among N_REQ
//            requesters. Optional watchdog: define UART_TX_ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int IDW           = 2,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  wire logic         system_clock,
  input  wire logic         cpu_rst,
  input  wire logic         clock_enable,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_ack;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_ptr;
  logic             r_start;
  logic [7:0]       r_data;
  logic [14:0]      r_bytes;
  logic [1:0]       r_delay;
  logic [7:0]       r_gap_cnt;

  logic [IDW-1:0]   w_win;
  logic [7:0]       w_data;
  logic [14:0]      w_bytes;
  logic [1:0]       w_delay;
  logic             w_wd_hit;
  logic             w_end;

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int c_WD_W = $clog2(TIMEOUT_TICKS + 1);
  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_err;

  assign w_wd_hit = (r_state == S_START || r_state == S_WAIT_DONE) && clock_enable &&
                    (r_wd_cnt == c_WD_W'(TIMEOUT_TICKS - 1));
  assign bus.err  = r_err;
`else
  assign w_wd_hit = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // Scan downward so the candidate closest to pointer+1 is assigned last and wins.
  always_comb begin
    int c;
    c       = 0;
    w_win   = r_ptr;
    w_data  = '0;
    w_bytes = '0;
    w_delay = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = (int'(r_ptr) + k) % N_REQ;
      if (bus.req[c]) begin
        w_win   = IDW'(c);
        w_data  = bus.req_data[8*c +: 8];
        w_bytes = bus.req_bytes[15*c +: 15];
        w_delay = bus.req_delay[2*c +: 2];
      end
    end
  end

  // A zero-byte frame ends in START without ever raising tx_start.
  always_comb begin
    w_end = 1'b0;
    case (r_state)
      S_START:     w_end = w_wd_hit || (r_bytes == 15'd0) || (bus.tx_busy && bus.tx_done);
      S_WAIT_DONE: w_end = w_wd_hit || bus.tx_done;
      default:     w_end = 1'b0;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (cpu_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ack     <= '0;
      r_id      <= '0;
      r_ptr     <= IDW'(N_REQ - 1);
      r_start   <= 1'b0;
      r_data    <= '0;
      r_bytes   <= '0;
      r_delay   <= '0;
      r_gap_cnt <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      r_wd_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_grant <= N_REQ'(1) << w_win;
            r_id    <= w_win;
            r_data  <= w_data;
            r_bytes <= w_bytes;
            r_delay <= w_delay;
            r_start <= (w_bytes != 15'd0);
            r_state <= S_START;
          end
        end
        S_START, S_WAIT_DONE: begin
          if (w_end) begin
            r_ack     <= r_grant;
            r_grant   <= '0;
            r_ptr     <= r_id;
            r_start   <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else if (r_state == S_START && bus.tx_busy) begin
            r_start <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'(GAP_TICKS)) begin
            r_state <= S_IDLE;
          end else if (clock_enable) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef UART_TX_ARB_WATCHDOG_EN
      if (r_state == S_IDLE) begin
        r_wd_cnt <= '0;
      end else if ((r_state == S_START || r_state == S_WAIT_DONE) && clock_enable) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_wd_hit) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  assign bus.grant        = r_grant;
  assign bus.ack          = r_ack;
  assign bus.active_id    = r_id;
  assign bus.arb_busy     = (r_state != S_IDLE);
  assign bus.tx_start     = r_start;
  assign bus.tx_data      = r_data;
  assign bus.tx_num_bytes = r_bytes;
  assign bus.tx_delay     = r_delay;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with a round-robin model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int GAP = 5;
  localparam int TMO = 8;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic ce      = 1'b0;
  logic ce_seen = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = N - 1;
  logic m_err    = 1'b0;

  uart_tx_arbiter_if #(.N_REQ(N), .IDW(IW)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N), .IDW(IW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)
  ) dut (
    .system_clock (clk),
    .cpu_rst      (rst),
    .clock_enable (ce),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ce = ($urandom_range(0, 2) == 0);
  always @(posedge clk) ce_seen <= ce;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester above the last owner, wrapping around.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"},  32'(bus.grant), 0);
    chk({tag, "_ack"},    32'(bus.ack), 0);
    chk({tag, "_id"},     32'(bus.active_id), 0);
    chk({tag, "_busy"},   32'(bus.arb_busy), 0);
    chk({tag, "_start"},  32'(bus.tx_start), 0);
    chk({tag, "_data"},   32'(bus.tx_data), 0);
    chk({tag, "_nbytes"}, 32'(bus.tx_num_bytes), 0);
    chk({tag, "_delay"},  32'(bus.tx_delay), 0);
    chk({tag, "_err"},    32'(bus.err), 0);
  endtask

  task automatic chk_lat(input logic [7:0] d, input logic [14:0] b, input logic [1:0] y);
    chk("tx_data",      32'(bus.tx_data), 32'(d));
    chk("tx_num_bytes", 32'(bus.tx_num_bytes), 32'(b));
    chk("tx_delay",     32'(bus.tx_delay), 32'(y));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    rst         = 1'b0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    m_ptr       = N - 1;
    m_err       = 1'b0;
  endtask

  task automatic randomize_slices(input bit allow_zero);
    bus.req_data  = $urandom();
    bus.req_delay = 8'($urandom());
    for (int i = 0; i < N; i++) begin
      bus.req_bytes[15*i +: 15] = (allow_zero && $urandom_range(0, 3) == 0) ?
                                  15'd0 : 15'($urandom_range(1, 32767));
    end
  endtask

  task automatic jitter(input int w, input bit drop);
    logic [N-1:0] m;
    m    = N'($urandom_range(0, (1 << N) - 1));
    m[w] = 1'b0;
    bus.req = bus.req ^ m;
    if (drop) bus.req[w] = 1'b0;
    bus.req_data  = $urandom();
    bus.req_bytes = 60'({$urandom(), $urandom()});
    bus.req_delay = 8'($urandom());
  endtask

  // Called at a falling edge with the arbiter idle and the requests in place.
  task automatic serve(input int bdly, input int ddly, input bit jit, input bit drop,
                       input bit keep, output int obs_id);
    int           w;
    logic [7:0]   e_data;
    logic [14:0]  e_bytes;
    logic [1:0]   e_dly;
    logic [N-1:0] e_gnt;
    w       = rr_pick(m_ptr, bus.req);
    e_data  = bus.req_data[8*w +: 8];
    e_bytes = bus.req_bytes[15*w +: 15];
    e_dly   = bus.req_delay[2*w +: 2];
    e_gnt   = '0;
    e_gnt[w] = 1'b1;
    @(negedge clk);
    obs_id = int'(bus.active_id);
    chk("grant",     32'(bus.grant), 32'(e_gnt));
    chk("active_id", 32'(bus.active_id), 32'(w));
    chk("arb_busy",  32'(bus.arb_busy), 1);
    chk("tx_start",  32'(bus.tx_start), 32'(e_bytes != 15'd0));
    chk_lat(e_data, e_bytes, e_dly);
    if (e_bytes == 15'd0) begin
      @(negedge clk);
      chk("ack_zero_frame", 32'(bus.ack), 32'(e_gnt));
      chk("start_zero_frame", 32'(bus.tx_start), 0);
    end else begin
      for (int c = 0; c < bdly; c++) begin
        if (jit) jitter(w, drop);
        @(negedge clk);
        chk("tx_start_hold", 32'(bus.tx_start), 1);
        chk("ack_early",     32'(bus.ack), 0);
        chk("err_idle",      32'(bus.err), 32'(m_err));
        chk("grant_hold",    32'(bus.grant), 32'(e_gnt));
        chk_lat(e_data, e_bytes, e_dly);
      end
      bus.tx_busy = 1'b1;
      bus.tx_done = (ddly == 0);
      @(negedge clk);
      chk("tx_start_drop", 32'(bus.tx_start), 0);
      if (ddly != 0) begin
        chk("ack_wait", 32'(bus.ack), 0);
        for (int c = 1; c < ddly; c++) begin
          if (jit) jitter(w, drop);
          @(negedge clk);
          chk("ack_wait",   32'(bus.ack), 0);
          chk("grant_wait", 32'(bus.grant), 32'(e_gnt));
          chk_lat(e_data, e_bytes, e_dly);
        end
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
        @(negedge clk);
      end
      chk("ack", 32'(bus.ack), 32'(e_gnt));
      bus.tx_done = 1'b0;
      bus.tx_busy = 1'b0;
    end
    chk("grant_clear", 32'(bus.grant), 0);
    chk_lat(e_data, e_bytes, e_dly);
    m_ptr = w;
    if (!keep) bus.req[w] = 1'b0;
  endtask

  // Counts ticks seen by the arbiter while it stays in the post-frame gap.
  task automatic gap_check();
    int ticks;
    int cyc;
    ticks = 0;
    cyc   = 0;
    while (bus.arb_busy === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("ack_one_cycle", 32'(bus.ack), 0);
      if (bus.arb_busy === 1'b1) ticks += int'(ce_seen);
    end
    chk("gap_ticks", 32'(ticks), 32'(GAP));
    chk("gap_idle",  32'(bus.arb_busy), 0);
  endtask

  initial begin
    int id;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_bytes = '0;
    bus.req_delay = '0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("por");
    rst   = 1'b0;
    m_ptr = N - 1;

    // Single requester, three-byte frame.
    randomize_slices(1'b0);
    bus.req = 4'b0001;
    bus.req_bytes[14:0] = 15'd3;
    serve(2, 3, 1'b0, 1'b0, 1'b0, id);
    chk("t1_owner", 32'(id), 0);
    gap_check();

    // All requesters held: fair rotation from reset.
    do_reset();
    randomize_slices(1'b0);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, 1'b1, id);
      chk("t2_order", 32'(id), 32'(k % N));
      gap_check();
    end

    // Zero-byte request, then pointer check.
    randomize_slices(1'b0);
    bus.req = 4'b0100;
    bus.req_bytes[44:30] = 15'd0;
    serve(0, 0, 1'b0, 1'b0, 1'b0, id);
    chk("t3_owner", 32'(id), 2);
    gap_check();
    randomize_slices(1'b0);
    bus.req = 4'b0101;
    serve(1, 1, 1'b0, 1'b0, 1'b0, id);
    chk("t3_next_owner", 32'(id), 0);
    gap_check();

    // Owner drops its request and changes its payload mid-frame.
    randomize_slices(1'b0);
    bus.req = 4'b0010;
    serve(3, 2, 1'b1, 1'b1, 1'b0, id);
    chk("t4_owner", 32'(id), 1);
    gap_check();

    // Reset while waiting for tx_done.
    randomize_slices(1'b0);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("t5_grant", 32'(bus.grant), 32'(4'b0010));
    bus.tx_busy = 1'b1;
    @(negedge clk);
    chk("t5_in_wait", 32'(bus.tx_start), 0);
    rst = 1'b1;
    bus.req = 4'b1000;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    chk_zero("t5_reset");
    rst   = 1'b0;
    m_ptr = N - 1;
    serve(1, 2, 1'b0, 1'b0, 1'b0, id);
    chk("t5_owner", 32'(id), 3);
    gap_check();

    // Controller never answers with busy.
    randomize_slices(1'b0);
    bus.req = 4'b0001;
`ifdef UART_TX_ARB_WATCHDOG_EN
    begin
      int ticks;
      int cyc;
      ticks = 0;
      cyc   = 0;
      @(negedge clk);
      chk("t6_grant", 32'(bus.grant), 1);
      do begin
        @(negedge clk);
        cyc++;
        ticks += int'(ce_seen);
        if (bus.ack == '0) chk("t6_start_hold", 32'(bus.tx_start), 1);
      end while (bus.ack == '0 && cyc < 500);
      chk("t6_ticks", 32'(ticks), 32'(TMO));
      chk("t6_ack",   32'(bus.ack), 1);
      chk("t6_start", 32'(bus.tx_start), 0);
      chk("t6_grant_clr", 32'(bus.grant), 0);
      chk("t6_err", 32'(bus.err), 1);
      m_err   = 1'b1;
      m_ptr   = 0;
      bus.req = '0;
      gap_check();
      chk("t6_err_sticky", 32'(bus.err), 1);
      do_reset();
    end
`else
    serve(40, 1, 1'b0, 1'b0, 1'b0, id);
    chk("t6_owner", 32'(id), 0);
    gap_check();
`endif

    // Randomized traffic against the model.
    for (int f = 0; f < 25; f++) begin
      randomize_slices(1'b1);
      bus.req = 4'($urandom_range(1, 15));
      serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)),
            1'b0, id);
      gap_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
